// File: rtl/allocate_memory.sv
// allocate_memory: next-fit free-slot allocator for the card linked-list RAM
module allocate_memory (
    input  logic        clock,
    input  logic        resetn,
    input  logic        enable,
    output logic        addr_found,
    output logic [9:0]  out_address,
    output logic [9:0]  ram_address,
    output logic        ram_clock,
    output logic [31:0] ram_data,
    output logic        ram_wren,
    input  logic [31:0] ram_q
);
    typedef enum logic [2:0] {IDLE, ADDR, CHECK, WRITE, DONE} state_t;
    state_t state, state_nx;
    logic [9:0] ptr, ptr_nx, probes, probes_nx, out_nx, ram_addr_nx, ptr_inc;
    logic unused_q;
    assign ram_clock  = clock;
    assign ram_data   = 32'h8000_0000;
    assign addr_found = state == DONE;
    assign ptr_inc    = (ptr == 10'd1023) ? 10'd1 : ptr + 10'd1;
    assign unused_q   = ^ram_q[30:0];
    // next-state and next register values; only bit 31 of a word decides free/used
    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        probes_nx   = probes;
        out_nx      = out_address;
        ram_addr_nx = ram_address;
        case (state)
            IDLE: if (enable) begin
                probes_nx   = '0;
                ram_addr_nx = ptr;
                state_nx    = ADDR;
            end
            ADDR: state_nx = CHECK;
            CHECK: if (!ram_q[31]) begin
                out_nx   = ptr;
                state_nx = WRITE;
            end else if (probes == 10'd1022) begin
                out_nx   = '0;
                state_nx = DONE;
            end else begin
                ptr_nx      = ptr_inc;
                probes_nx   = probes + 10'd1;
                ram_addr_nx = ptr_inc;
                state_nx    = ADDR;
            end
            WRITE: begin
                ptr_nx   = ptr_inc;
                state_nx = DONE;
            end
            DONE: if (!enable) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // state and datapath registers; write enable is registered so it is high exactly in WRITE
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            ptr         <= 10'd1;
            probes      <= '0;
            out_address <= '0;
            ram_address <= '0;
            ram_wren    <= 1'b0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            probes      <= probes_nx;
            out_address <= out_nx;
            ram_address <= ram_addr_nx;
            ram_wren    <= state_nx == WRITE;
        end
    end
endmodule

// File: tb/tb_allocate_memory.sv
// tb_allocate_memory: randomized and directed check of allocate_memory against a next-fit scan model
module tb_allocate_memory;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        addr_found, ram_clock, ram_wren;
    logic [9:0]  out_address, ram_address;
    logic [31:0] ram_data, ram_q;
    logic [31:0] ram [1024];
    logic        tb_we = 1'b0, tb_fill = 1'b0, tb_fill_used = 1'b0;
    logic [9:0]  tb_wa = '0;
    logic [31:0] tb_wd = '0;
    logic [31:0] m_mem [1024];
    int          m_ptr = 1;
    logic        exp_found = 1'b0, exp_wren = 1'b0;
    logic [9:0]  exp_out = '0;
    bit          chk = 1'b0;
    int          vectors = 0, miscompares = 0;

    allocate_memory dut (
        .clock(clock), .resetn(resetn), .enable(enable), .addr_found(addr_found),
        .out_address(out_address), .ram_address(ram_address), .ram_clock(ram_clock),
        .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    always #5 clock = ~clock;

    // registered-address synchronous RAM with a bench-side backdoor write and bulk fill
    always @(posedge clock) begin
        if (tb_fill)
            for (int i = 0; i < 1024; i++) ram[i] <= tb_fill_used ? (32'h8000_0000 | 32'(i)) : 32'h0;
        else if (tb_we)
            ram[tb_wa] <= tb_wd;
        else if (ram_wren)
            ram[ram_address] <= ram_data;
        ram_q <= ram[ram_address];
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int nxt(input int a);
        return (a == 1023) ? 1 : a + 1;
    endfunction

    // per-cycle compare of DUT outputs against the model expectations
    always @(negedge clock) begin
        if (chk) begin
            cmp("addr_found", 32'(addr_found), 32'(exp_found));
            cmp("ram_wren", 32'(ram_wren), 32'(exp_wren));
            cmp("out_address", 32'(out_address), 32'(exp_out));
            if (exp_wren) begin
                cmp("ram_address", 32'(ram_address), 32'(exp_out));
                cmp("ram_data", ram_data, 32'h8000_0000);
            end
        end
    end

    task automatic fill(input bit used);
        for (int i = 0; i < 1024; i++) m_mem[i] = used ? (32'h8000_0000 | 32'(i)) : 32'h0;
        tb_fill_used = used;
        tb_fill = 1'b1;
        @(posedge clock);
        #1 tb_fill = 1'b0;
    endtask

    task automatic set_word(input int a, input logic [31:0] v);
        m_mem[a] = v;
        tb_wa = 10'(a);
        tb_wd = v;
        tb_we = 1'b1;
        @(posedge clock);
        #1 tb_we = 1'b0;
    endtask

    task automatic request(input bit drop_early, output int rise, output logic [9:0] got);
        int p, k, fa, lat, stop;
        bit found;
        p = m_ptr; k = 0; fa = 0; found = 1'b0;
        for (int i = 0; i < 1023 && !found; i++) begin
            if (!m_mem[p][31]) begin
                found = 1'b1; fa = p; k = i;
            end else p = nxt(p);
        end
        lat  = found ? 3 + 2 * k : 2046;
        stop = drop_early ? lat + 2 : lat + 4;
        rise = -1;
        @(negedge clock);
        enable = 1'b1;
        for (int j = 0; j <= stop; j++) begin
            @(posedge clock);
            #1;
            exp_wren  = found && j == lat - 1;
            exp_found = drop_early ? (j == lat) : (j >= lat && j <= lat + 2);
            if (found && j == lat - 1) exp_out = 10'(fa);
            if (!found && j == lat) exp_out = '0;
            if (j == (drop_early ? 0 : lat + 2)) enable = 1'b0;
            if (addr_found && rise < 0) rise = j;
        end
        got = out_address;
        if (found) begin
            m_mem[fa] = 32'h8000_0000;
            m_ptr = nxt(fa);
        end else
            for (int i = 0; i < 1022; i++) m_ptr = nxt(m_ptr);
    endtask

    task automatic reset_check(input int scan_cycles);
        if (scan_cycles > 0) begin
            @(negedge clock);
            enable = 1'b1;
            repeat (scan_cycles) @(posedge clock);
        end else @(posedge clock);
        #2;
        chk = 1'b0;
        resetn = 1'b0;
        #1;
        cmp("rst_addr_found", 32'(addr_found), 32'h0);
        cmp("rst_out_address", 32'(out_address), 32'h0);
        cmp("rst_ram_wren", 32'(ram_wren), 32'h0);
        cmp("rst_ram_address", 32'(ram_address), 32'h0);
        enable = 1'b0;
        m_ptr = 1;
        exp_out = '0;
        exp_found = 1'b0;
        exp_wren = 1'b0;
        @(negedge clock);
        #1;
        resetn = 1'b1;
        chk = 1'b1;
    endtask

    initial begin
        int rise, p, n;
        logic [9:0] got;
        fill(1'b0);
        reset_check(0);
        request(1'b0, rise, got);
        cmp("first_addr", 32'(got), 32'd1);
        cmp("first_rise", 32'(rise), 32'd3);
        cmp("first_write", ram[1], 32'h8000_0000);
        request(1'b0, rise, got);
        cmp("second_addr", 32'(got), 32'd2);
        for (int a = 3; a <= 5; a++) set_word(a, 32'h8000_0000 | 32'($urandom_range(0, 16'hffff)));
        set_word(6, 32'h0000_03FF);
        request(1'b0, rise, got);
        cmp("skip_addr", 32'(got), 32'd6);
        cmp("skip_rise", 32'(rise), 32'd9);
        fill(1'b1);
        set_word(1022, 32'h7FFF_FFFF);
        request(1'b0, rise, got);
        cmp("far_addr", 32'(got), 32'd1022);
        cmp("far_rise", 32'(rise), 32'd2033);
        set_word(1, 32'h0);
        request(1'b0, rise, got);
        cmp("wrap_addr", 32'(got), 32'd1);
        cmp("wrap_rise", 32'(rise), 32'd5);
        set_word(2, 32'h0001_0005);
        request(1'b0, rise, got);
        cmp("after_wrap_addr", 32'(got), 32'd2);
        request(1'b0, rise, got);
        cmp("full_addr", 32'(got), 32'd0);
        cmp("full_rise", 32'(rise), 32'd2046);
        cmp("full_untouched", ram[1023], 32'h8000_03FF);
        reset_check(0);
        set_word(9, 32'h0);
        request(1'b0, rise, got);
        cmp("post_reset_addr", 32'(got), 32'd9);
        cmp("post_reset_rise", 32'(rise), 32'd19);
        reset_check(20);
        set_word(1, 32'h0);
        request(1'b0, rise, got);
        cmp("restart_addr", 32'(got), 32'd1);
        cmp("restart_rise", 32'(rise), 32'd3);
        set_word(40, 32'h0000_1234);
        request(1'b1, rise, got);
        cmp("drop_addr", 32'(got), 32'd40);
        cmp("drop_rise", 32'(rise), 32'd79);
        for (int r = 0; r < 20; r++) begin
            p = m_ptr;
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) begin
                set_word(p, 32'h8000_0000 | $urandom);
                p = nxt(p);
            end
            set_word(p, $urandom & 32'h7FFF_FFFF);
            if ($urandom_range(0, 3) == 0) set_word($urandom_range(1, 1023), $urandom & 32'h7FFF_FFFF);
            request(1'($urandom_range(0, 1)), rise, got);
            cmp("rand_write", ram[got], 32'h8000_0000);
        end
        repeat (2) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
